// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: control word layout, access size
// encodings, FSM state encoding and store lane helpers.
package mem_stage_pkg;

    localparam int CTRL_W         = 6;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_SIZE_LO   = 3;
    localparam int CTRL_SIZE_HI   = 4;
    localparam int CTRL_SIGNED    = 5;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: store_be = 4'b0001 << lo;
            SIZE_HALF: store_be = lo[1] ? 4'b1100 : 4'b0011;
            default:   store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: store_wdata = {4{data[7:0]}};
            SIZE_HALF: store_wdata = {2{data[15:0]}};
            default:   store_wdata = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane extraction: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it; word loads pass straight through.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension
    always_comb begin
        byte_s = rdata[7:0];
        half_s = rdata[15:0];
        data   = rdata;
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size)
            SIZE_BYTE: data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SIZE_HALF: data = {{16{sign_ext & half_s[15]}}, half_s};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: IDLE/ACCESS handshake with the data memory, store
// lane steering, load alignment and access timeout. Optional alignment
// trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ex_result,
    input  logic [4:0]        ex_wreg_addr,
    input  logic [31:0]       ex_mem_wdata,
    input  logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_req,
    output logic              dm_req,
    output logic              dm_we,
    output logic [31:0]       dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              fwd_we,
    output logic [4:0]        fwd_addr,
    output logic [31:0]       fwd_data,
    output logic              addr_err,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       lo_r;
    logic [1:0]       size_r;
    logic             sign_r;
    logic             load_r;
    logic             rw_r;
    logic [4:0]       wreg_r;

    logic [1:0]       size_s;
    logic [1:0]       eff_lo_s;
    logic             memop_s;
    logic             aligned_s;
    logic [31:0]      ld_data_s;

    assign size_s  = ex_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO];
    assign memop_s = ex_ctrl[CTRL_MEM_READ] | ex_ctrl[CTRL_MEM_WRITE];

    // Alignment classification; without trapping the offending low bits are cleared
    always_comb begin
        aligned_s = 1'b1;
        eff_lo_s  = ex_result[1:0];
        case (size_s)
            SIZE_BYTE: begin
                aligned_s = 1'b1;
                eff_lo_s  = ex_result[1:0];
            end
            SIZE_HALF: begin
`ifdef MEM_ALIGN_CHECK_EN
                aligned_s = ~ex_result[0];
`else
                eff_lo_s  = {ex_result[1], 1'b0};
`endif
            end
            default: begin
`ifdef MEM_ALIGN_CHECK_EN
                aligned_s = (ex_result[1:0] == 2'b00);
`else
                eff_lo_s  = 2'b00;
`endif
            end
        endcase
    end

    assign stall_req = ((state_r == ST_IDLE) & ex_valid & memop_s & aligned_s) |
                       ((state_r == ST_ACCESS) & ~dm_ack);

    assign fwd_we   = wb_valid & wb_we;
    assign fwd_addr = wb_addr;
    assign fwd_data = wb_data;

    mem_load_align u_load_align (
        .rdata    (dm_rdata),
        .addr     (lo_r),
        .size     (size_r),
        .sign_ext (sign_r),
        .data     (ld_data_s)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic addr_err_r;
    assign addr_err = addr_err_r;
`else
    assign addr_err = 1'b0;
`endif

    // Stage FSM with all bus and write-back outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            lo_r     <= 2'b00;
            size_r   <= 2'b00;
            sign_r   <= 1'b0;
            load_r   <= 1'b0;
            rw_r     <= 1'b0;
            wreg_r   <= 5'd0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= 32'd0;
            dm_be    <= 4'd0;
            dm_wdata <= 32'd0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= 5'd0;
            wb_data  <= 32'd0;
            bus_err  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err_r <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid && memop_s && aligned_s) begin
                        state_r  <= ST_ACCESS;
                        cnt_r    <= '0;
                        lo_r     <= eff_lo_s;
                        size_r   <= size_s;
                        sign_r   <= ex_ctrl[CTRL_SIGNED];
                        load_r   <= ex_ctrl[CTRL_MEM_READ] & ~ex_ctrl[CTRL_MEM_WRITE];
                        rw_r     <= ex_ctrl[CTRL_REG_WRITE];
                        wreg_r   <= ex_wreg_addr;
                        dm_req   <= 1'b1;
                        dm_we    <= ex_ctrl[CTRL_MEM_WRITE];
                        dm_addr  <= {ex_result[31:2], 2'b00};
                        dm_be    <= store_be(size_s, eff_lo_s);
                        dm_wdata <= store_wdata(size_s, ex_mem_wdata);
`ifdef MEM_ALIGN_CHECK_EN
                    end else if (ex_valid && memop_s) begin
                        wb_valid   <= 1'b1;
                        wb_we      <= 1'b0;
                        wb_addr    <= ex_wreg_addr;
                        wb_data    <= ex_result;
                        addr_err_r <= 1'b1;
`endif
                    end else if (ex_valid) begin
                        wb_valid <= 1'b1;
                        wb_we    <= ex_ctrl[CTRL_REG_WRITE] & (ex_wreg_addr != 5'd0);
                        wb_addr  <= ex_wreg_addr;
                        wb_data  <= ex_result;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (dm_ack) begin
                        state_r  <= ST_IDLE;
                        dm_req   <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_addr  <= wreg_r;
                        if (load_r) begin
                            wb_we   <= rw_r & (wreg_r != 5'd0);
                            wb_data <= ld_data_s;
                        end else begin
                            wb_we   <= 1'b0;
                            wb_data <= 32'd0;
                        end
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Abandon the access: retire without a register write
                        state_r  <= ST_IDLE;
                        dm_req   <= 1'b0;
                        bus_err  <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_addr  <= wreg_r;
                        wb_data  <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    dm_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected retirements plus
// direct checks of bus lanes, stall length, timeout and reset behaviour.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TB_TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic [31:0]       ex_result;
    logic [4:0]        ex_wreg_addr;
    logic [31:0]       ex_mem_wdata;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall_req;
    logic              dm_req, dm_we, dm_ack;
    logic [31:0]       dm_addr, dm_wdata, dm_rdata;
    logic [3:0]        dm_be;
    logic              wb_valid, wb_we, fwd_we, addr_err, bus_err;
    logic [4:0]        wb_addr, fwd_addr;
    logic [31:0]       wb_data, fwd_data;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_data;
        logic        berr;
        logic        aerr;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;
    int  stall_cnt = 0;

    mem_stage #(.TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_wreg_addr(ex_wreg_addr),
        .ex_mem_wdata(ex_mem_wdata), .ex_ctrl(ex_ctrl),
        .stall_req(stall_req),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic rw, input logic rd, input logic wr,
                                                  input logic [1:0] sz, input logic sg);
        logic [CTRL_W-1:0] c;
        c = '0;
        c[CTRL_REG_WRITE] = rw;
        c[CTRL_MEM_READ]  = rd;
        c[CTRL_MEM_WRITE] = wr;
        c[CTRL_SIZE_HI:CTRL_SIZE_LO] = sz;
        c[CTRL_SIGNED]    = sg;
        return c;
    endfunction

    // Retirement monitor: every wb_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (stall_req === 1'b1) stall_cnt++;
        if (!rst) begin
            if (wb_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("wb_unexpected", {31'd0, wb_valid}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("wb_we", {31'd0, wb_we}, {31'd0, mon_e.we});
                    check_val("fwd_we", {31'd0, fwd_we}, {31'd0, mon_e.we});
                    check_val("bus_err", {31'd0, bus_err}, {31'd0, mon_e.berr});
                    check_val("addr_err", {31'd0, addr_err}, {31'd0, mon_e.aerr});
                    if (mon_e.chk_data) begin
                        check_val("wb_addr", {27'd0, wb_addr}, {27'd0, mon_e.addr});
                        check_val("wb_data", wb_data, mon_e.data);
                        check_val("fwd_addr", {27'd0, fwd_addr}, {27'd0, mon_e.addr});
                        check_val("fwd_data", fwd_data, mon_e.data);
                    end
                end
            end else if (bus_err || addr_err || fwd_we) begin
                check_val("stray_pulse", {29'd0, fwd_we, bus_err, addr_err}, 32'd0);
            end
        end
    end

    task automatic check_dm(input string tag, input logic [31:0] ea, input logic st,
                            input logic [3:0] eb, input logic [31:0] ew);
        check_val({tag, "_req"}, {31'd0, dm_req}, 32'd1);
        check_val({tag, "_addr"}, dm_addr, ea);
        check_val({tag, "_we"}, {31'd0, dm_we}, {31'd0, st});
        if (st) begin
            check_val({tag, "_be"}, {28'd0, dm_be}, {28'd0, eb});
            check_val({tag, "_wdata"}, dm_wdata, ew);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] res, input logic [4:0] wreg,
                          input logic [31:0] wdat, input logic [CTRL_W-1:0] ctrl,
                          input logic access, input int ack_wait, input logic [31:0] rdata,
                          input logic [31:0] ea, input logic [3:0] eb, input logic [31:0] ew,
                          input int exp_stall, input sb_t exp);
        @(posedge clk); #1;
        stall_cnt    = 0;
        ex_valid     = 1'b1;
        ex_result    = res;
        ex_wreg_addr = wreg;
        ex_mem_wdata = wdat;
        ex_ctrl      = ctrl;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (access) begin
            for (int w = 0; w < ack_wait; w++) begin
                @(negedge clk);
                check_dm({tag, "_wait"}, ea, ctrl[CTRL_MEM_WRITE], eb, ew);
                @(posedge clk); #1;
            end
            dm_ack   = 1'b1;
            dm_rdata = rdata;
            @(negedge clk);
            if (ack_wait < TB_TO) check_dm({tag, "_ack"}, ea, ctrl[CTRL_MEM_WRITE], eb, ew);
            @(posedge clk); #1;
            dm_ack   = 1'b0;
            dm_rdata = 32'd0;
        end
        @(negedge clk);
        check_val({tag, "_req_low"}, {31'd0, dm_req}, 32'd0);
        check_val({tag, "_stall_low"}, {31'd0, stall_req}, 32'd0);
        check_val({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_result = 32'd0; ex_wreg_addr = 5'd0;
        ex_mem_wdata = 32'd0; ex_ctrl = '0; dm_ack = 1'b0; dm_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_wb", {wb_valid, wb_we, wb_addr, 25'd0}, 32'd0);
        check_val("rst_wb_data", wb_data, 32'd0);
        check_val("rst_dm", {dm_req, dm_we, dm_be, 26'd0}, 32'd0);
        check_val("rst_dm_addr", dm_addr, 32'd0);
        check_val("rst_dm_wdata", dm_wdata, 32'd0);
        check_val("rst_misc", {stall_req, addr_err, bus_err, fwd_we, 28'd0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("add", 32'h12345678, 5'd5, 32'd0, mk_ctrl(1'b1, 1'b0, 1'b0, 2'b10, 1'b0),
               1'b0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0, '{1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0, 1'b0});
        run_op("add_r0", 32'hDEADBEEF, 5'd0, 32'd0, mk_ctrl(1'b1, 1'b0, 1'b0, 2'b10, 1'b0),
               1'b0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0, '{1'b0, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        run_op("lb", 32'h00001003, 5'd6, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b00, 1'b1),
               1'b1, 3, 32'h80FFFFFF, 32'h00001000, 4'd0, 32'd0, 4, '{1'b1, 5'd6, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0});
        run_op("sh", 32'h00002002, 5'd0, 32'h0000BEEF, mk_ctrl(1'b0, 1'b0, 1'b1, 2'b01, 1'b0),
               1'b1, 0, 32'd0, 32'h00002000, 4'b1100, 32'hBEEFBEEF, 1, '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        run_op("sb", 32'h00004001, 5'd0, 32'h123456A5, mk_ctrl(1'b0, 1'b0, 1'b1, 2'b00, 1'b0),
               1'b1, 1, 32'd0, 32'h00004000, 4'b0010, 32'hA5A5A5A5, 2, '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        run_op("sw", 32'h00005004, 5'd0, 32'hCAFEF00D, mk_ctrl(1'b0, 1'b0, 1'b1, 2'b10, 1'b0),
               1'b1, 2, 32'd0, 32'h00005004, 4'b1111, 32'hCAFEF00D, 3, '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        run_op("lhu", 32'h00006002, 5'd7, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b01, 1'b0),
               1'b1, 1, 32'h80017FFE, 32'h00006000, 4'd0, 32'd0, 2, '{1'b1, 5'd7, 32'h00008001, 1'b1, 1'b0, 1'b0});
        run_op("lh", 32'h00006000, 5'd8, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b01, 1'b1),
               1'b1, 0, 32'h12348765, 32'h00006000, 4'd0, 32'd0, 1, '{1'b1, 5'd8, 32'hFFFF8765, 1'b1, 1'b0, 1'b0});
        run_op("lbu", 32'h00006001, 5'd10, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b00, 1'b0),
               1'b1, 2, 32'h11223344, 32'h00006000, 4'd0, 32'd0, 3, '{1'b1, 5'd10, 32'h00000033, 1'b1, 1'b0, 1'b0});
        run_op("lw_sz3", 32'h00007000, 5'd11, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b11, 1'b1),
               1'b1, 0, 32'hA5A55A5A, 32'h00007000, 4'd0, 32'd0, 1, '{1'b1, 5'd11, 32'hA5A55A5A, 1'b1, 1'b0, 1'b0});
        run_op("lw_r0", 32'h00007008, 5'd0, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0),
               1'b1, 0, 32'h0F0F0F0F, 32'h00007008, 4'd0, 32'd0, 1, '{1'b0, 5'd0, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0});
`ifdef MEM_ALIGN_CHECK_EN
        run_op("lw_mis", 32'h00003001, 5'd9, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0),
               1'b0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0, '{1'b0, 5'd9, 32'd0, 1'b0, 1'b0, 1'b1});
`else
        run_op("lw_mis", 32'h00003001, 5'd9, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0),
               1'b1, 0, 32'h01020304, 32'h00003000, 4'd0, 32'd0, 1, '{1'b1, 5'd9, 32'h01020304, 1'b1, 1'b0, 1'b0});
        run_op("lh_mis", 32'h00006003, 5'd12, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b01, 1'b1),
               1'b1, 0, 32'hFFEE1122, 32'h00006000, 4'd0, 32'd0, 1, '{1'b1, 5'd12, 32'hFFFFFFEE, 1'b1, 1'b0, 1'b0});
`endif
        // Timeout: no ack for TB_TO cycles, then a late ack arrives in IDLE
        run_op("tmo", 32'h00008000, 5'd13, 32'd0, mk_ctrl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0),
               1'b1, TB_TO, 32'h00000055, 32'h00008000, 4'd0, 32'd0, TB_TO + 1,
               '{1'b0, 5'd13, 32'd0, 1'b0, 1'b1, 1'b0});

        // Reset on the second ACCESS cycle, ack one cycle later
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_result = 32'h00009000; ex_wreg_addr = 5'd3;
        ex_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h77777777;
        @(negedge clk);
        check_val("rstacc_req", {31'd0, dm_req}, 32'd0);
        check_val("rstacc_wb", {31'd0, wb_valid}, 32'd0);
        check_val("rstacc_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0; dm_rdata = 32'd0;
        @(negedge clk);
        check_val("late_ack_wb", {31'd0, wb_valid}, 32'd0);
        check_val("late_ack_req", {31'd0, dm_req}, 32'd0);

        run_op("add_post", 32'h0BADF00D, 5'd31, 32'd0, mk_ctrl(1'b1, 1'b0, 1'b0, 2'b10, 1'b0),
               1'b0, 0, 32'd0, 32'd0, 4'd0, 32'd0, 0, '{1'b1, 5'd31, 32'h0BADF00D, 1'b1, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        check_val("sb_drain", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
